axis_burst_drainer: RTL and testbench
=====================================

AXIS_BURST_DRAINER -- requirements
Module: axis_burst_drainer

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 128, the data width in bits of both streams.
REQ-002 SHALL have parameter BURST_LEN, default 16, the maximum beats per output packet; legal range 2..256.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the idle cycles before a partial burst is flushed; minimum 1.
REQ-004 SHALL have ports aclk, input, 1: the single clock; aresetn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports S_AXIS_TDATA, input, TDATA_WIDTH; S_AXIS_TVALID, input, 1; S_AXIS_TREADY, output, 1: the upstream FIFO read side.
REQ-006 SHALL have port fifo_count, input, 32: the upstream FIFO occupancy (write-side data count).
REQ-007 SHALL have ports M_AXIS_TDATA, output, TDATA_WIDTH; M_AXIS_TVALID, output, 1; M_AXIS_TLAST, output, 1; M_AXIS_TREADY, input, 1: the packetized output.
REQ-008 SHALL have ports busy, output, 1: high while not IDLE; burst_count, output, 32: the number of completed packets.

Function
REQ-009 SHALL implement FSM states IDLE and BURST.
REQ-010 In IDLE, if fifo_count >= BURST_LEN, the block SHALL latch beats_left = BURST_LEN and enter BURST on the next cycle.
REQ-011 In IDLE, the idle timer SHALL increment each cycle while 0 < fifo_count < BURST_LEN and clear whenever fifo_count == 0.
REQ-012 When the timer reaches TIMEOUT_CYCLES-1, the block SHALL latch beats_left = fifo_count (a flush) and enter BURST.
REQ-013 When full-burst and timeout conditions are true in the same cycle, the full burst SHALL take precedence.
REQ-014 The idle timer SHALL clear on entry to BURST.
REQ-015 S_AXIS_TREADY SHALL be high only in BURST while beats_left > 0 and the output stage can accept a beat.
REQ-016 S_AXIS_TREADY SHALL be combinational with no dependence on S_AXIS_TVALID.
REQ-017 Each S handshake SHALL decrement beats_left by 1.
REQ-018 The beat that takes beats_left from 1 to 0 SHALL carry TLAST=1; all other beats SHALL carry TLAST=0.
REQ-019 After the TLAST beat is accepted on S, the FSM SHALL return to IDLE and burst_count SHALL increment by 1, wrapping modulo 2^32.
REQ-020 If S_AXIS_TVALID drops mid-burst, the FSM SHALL stay in BURST and wait with no timeout.
REQ-021 Packet length SHALL equal the latched beats_left; a change in fifo_count mid-burst SHALL have no effect.
REQ-022 The output stage SHALL be a 2-entry register slice.
REQ-023 Latency from S handshake to M_AXIS_TVALID SHALL be 1 cycle.
REQ-024 Throughput SHALL be 1 beat/cycle while M_AXIS_TREADY=1.
REQ-025 M_AXIS_TREADY SHALL NOT combinationally affect M_AXIS_TVALID or M_AXIS_TDATA.
REQ-026 While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_TDATA and M_AXIS_TLAST SHALL be held stable.
REQ-027 busy SHALL be 1 in BURST and SHALL remain 1 until the output slice is empty after the last beat.
REQ-028 A new burst SHALL be able to start the cycle after return to IDLE, with no bubble required beyond the IDLE evaluation cycle.

Reset
REQ-029 On aresetn=0, asynchronously: FSM=IDLE; beats_left, timer and burst_count SHALL be 0; slice SHALL be empty.
REQ-030 During reset: M_AXIS_TVALID=0, M_AXIS_TLAST=0, S_AXIS_TREADY=0, busy=0; M_AXIS_TDATA SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL discard in-flight beats; after deassertion, no partial TLAST packet SHALL be emitted.
REQ-032 Reset deassertion SHALL be synchronized by the integrator; the block SHALL accept any deassertion edge.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=0, BURST=1) and the count width constant (32).
REQ-034 The output stage SHALL be one sub-module, axis_reg_slice (parameter TDATA_WIDTH+1 for data plus TLAST).
REQ-035 The implementation SHALL target 150-300 lines of RTL in total.

Verification
REQ-036 Scenario 1: fifo_count=16, 16 sequential words 0..15 presented, M_AXIS_TREADY=1 -> one packet of 16 beats in order, TLAST on word 15, burst_count=1.
REQ-037 Scenario 2: fifo_count=3, held constant, TIMEOUT_CYCLES=8 -> no transfer for 8 idle cycles, then a 3-beat packet with TLAST on beat 3.
REQ-038 Scenario 3: fifo_count=40 with continuous data -> two 16-beat packets and no timeout flush; 8 beats remain until timeout, then an 8-beat packet; burst_count=3.
REQ-039 Scenario 4: random M_AXIS_TREADY (50%) during a 16-beat burst -> no data loss or duplication, data stable while stalled, exactly one TLAST.
REQ-040 Scenario 5: aresetn pulsed low at beat 7 of 16 -> all outputs 0 immediately; the next packet after reset is a full, correctly framed burst.
REQ-041 Scenario 6: S_AXIS_TVALID gapped 1-on/1-off mid-burst -> packet length still 16; busy stays 1 throughout.

Source files
------------

// File: rtl/axis_burst_drainer_pkg.sv
// Shared FSM encoding and counter width for the AXI-Stream burst drainer.
package axis_burst_drainer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int COUNT_W = 32;

endpackage

// File: rtl/axis_burst_drainer_reg_slice.sv
// Two-entry AXI-Stream register slice: registered outputs plus a skid entry so
// the upstream ready never depends on the downstream ready in the same cycle.
module axis_reg_slice #(
  parameter int WIDTH = 129
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             empty
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  assign in_ready = !skid_valid;
  assign empty    = !out_valid && !skid_valid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output register is free this cycle: refill from skid first, else from input.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= in_data;
        end
      end
    end else if (in_valid && in_ready) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_burst_drainer.sv
// Drains an upstream FIFO into fixed-length AXI-Stream packets, flushing a
// partial packet when the FIFO sits non-empty but short of a burst for too long.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | watch fifo_count; start a full burst or count toward a flush
// BURST | forward latched beats_left beats, TLAST on the final one
module axis_burst_drainer
  import axis_burst_drainer_pkg::*;
#(
  parameter int TDATA_WIDTH    = 128,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  input  logic [COUNT_W-1:0]     fifo_count,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  output logic                   M_AXIS_TLAST,
  input  logic                   M_AXIS_TREADY,
  output logic                   busy,
  output logic [COUNT_W-1:0]     burst_count
);

  localparam int BEATS_W = $clog2(BURST_LEN + 1);
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t               state, state_nxt;
  logic [BEATS_W-1:0]   beats_left, beats_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [COUNT_W-1:0]   count_nxt;

  logic                 slice_in_ready;
  logic                 slice_empty;
  logic [TDATA_WIDTH:0] out_word;
  logic                 s_ready;
  logic                 s_fire;
  logic                 last_beat;
  logic                 full_ok;
  logic                 pending;
  logic                 timed_out;

  assign s_ready   = (state == BURST) && (beats_left != '0) && slice_in_ready;
  assign s_fire    = s_ready && S_AXIS_TVALID;
  assign last_beat = (beats_left == BEATS_W'(1));
  assign full_ok   = (fifo_count >= COUNT_W'(BURST_LEN));
  assign pending   = (fifo_count != '0);
  assign timed_out = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      beats_left  <= '0;
      timer       <= '0;
      burst_count <= '0;
    end else begin
      state       <= state_nxt;
      beats_left  <= beats_nxt;
      timer       <= timer_nxt;
      burst_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beats_nxt = beats_left;
    timer_nxt = timer;
    count_nxt = burst_count;
    case (state)
      IDLE: begin
        // A full burst wins over a simultaneous timeout.
        if (full_ok) begin
          state_nxt = BURST;
          beats_nxt = BEATS_W'(BURST_LEN);
          timer_nxt = '0;
        end else if (pending && timed_out) begin
          state_nxt = BURST;
          beats_nxt = fifo_count[BEATS_W-1:0];
          timer_nxt = '0;
        end else if (pending) begin
          timer_nxt = timer + 1'b1;
        end else begin
          timer_nxt = '0;
        end
      end
      BURST: begin
        if (s_fire) begin
          beats_nxt = beats_left - 1'b1;
          if (last_beat) begin
            state_nxt = IDLE;
            count_nxt = burst_count + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  axis_reg_slice #(
    .WIDTH (TDATA_WIDTH + 1)
  ) u_slice (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   ({last_beat, S_AXIS_TDATA}),
    .in_valid  (s_fire),
    .in_ready  (slice_in_ready),
    .out_data  (out_word),
    .out_valid (M_AXIS_TVALID),
    .out_ready (M_AXIS_TREADY),
    .empty     (slice_empty)
  );

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TDATA  = out_word[TDATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = out_word[TDATA_WIDTH];
  assign busy          = (state == BURST) || !slice_empty;

endmodule

// File: tb/tb_axis_burst_drainer.sv
// Directed bench for axis_burst_drainer: upstream FIFO model, output capture
// queue, and hand-computed packet framing per scenario.
module tb_axis_burst_drainer;

  localparam int DW = 16;
  localparam int BL = 16;
  localparam int TO = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic          S_AXIS_TVALID = 1'b0;
  logic          S_AXIS_TREADY;
  logic [31:0]   fifo_count = '0;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY = 1'b1;
  logic          busy;
  logic [31:0]   burst_count;

  axis_burst_drainer #(
    .TDATA_WIDTH    (DW),
    .BURST_LEN      (BL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .fifo_count    (fifo_count),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .busy          (busy),
    .burst_count   (burst_count)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int word = 0;
  int avail = 0;
  int fires = 0;
  int first_fire = -1;
  int busy_drops = 0;
  bit phase = 1'b0;
  bit watch_busy = 1'b0;
  bit seen_last = 1'b0;
  bit stalled = 1'b0;
  logic [DW:0] hold_word;
  logic [DW:0] got[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Output capture and hold-while-stalled checking.
  always @(negedge aclk) begin
    if (!aresetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(M_AXIS_TVALID), 64'd1);
        check("stall_word", 64'({M_AXIS_TLAST, M_AXIS_TDATA}), 64'(hold_word));
      end
      stalled   = M_AXIS_TVALID && !M_AXIS_TREADY;
      hold_word = {M_AXIS_TLAST, M_AXIS_TDATA};
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        got.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
        if (M_AXIS_TLAST) seen_last = 1'b1;
      end
    end
  end

  task automatic apply_inputs(input bit gap, input bit rnd);
    S_AXIS_TVALID = (avail > 0) && (!gap || phase);
    S_AXIS_TDATA  = DW'(word);
    fifo_count    = 32'(avail);
    M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic load(input int n, input int base);
    avail = n;
    word  = base;
    fires = 0;
    first_fire = -1;
    got.delete();
    seen_last = 1'b0;
    apply_inputs(1'b0, 1'b0);
  endtask

  task automatic drive(input int ncyc, input int stop_fires, input bit gap, input bit rnd);
    bit fire;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge aclk);
      fire = S_AXIS_TREADY && S_AXIS_TVALID;
      if (fire && first_fire < 0) first_fire = i;
      if (watch_busy && fires > 0 && !seen_last && !busy) busy_drops++;
      @(posedge aclk);
      #1;
      if (fire) begin
        word++;
        avail--;
        fires++;
      end
      phase = ~phase;
      apply_inputs(gap, rnd);
      if (stop_fires > 0 && fires >= stop_fires) return;
    end
  endtask

  task automatic check_pkt(input string tag, input int n, input int base);
    check({tag, "_beats"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      check({tag, "_data"}, 64'(got[i][DW-1:0]), 64'(DW'(base + i)));
      check({tag, "_last"}, 64'(got[i][DW]), 64'(((i % BL) == BL - 1) || (i == n - 1)));
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sready"}, 64'(S_AXIS_TREADY), 64'd0);
  endtask

  initial begin
    #2;
    check("rst_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    check("rst_mlast", 64'(M_AXIS_TLAST), 64'd0);
    check("rst_mdata", 64'(M_AXIS_TDATA), 64'd0);
    check("rst_sready", 64'(S_AXIS_TREADY), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(burst_count), 64'd0);
    #20;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // S1: one full burst of words 0..15
    load(16, 0);
    drive(40, 0, 1'b0, 1'b0);
    check_pkt("s1", 16, 0);
    check("s1_count", 64'(burst_count), 64'd1);
    check_quiet("s1");

    // S2: 3 words wait out the 8-cycle timeout, then flush
    load(3, 16'h0100);
    drive(30, 0, 1'b0, 1'b0);
    check("s2_first_fire", 64'(first_fire), 64'd8);
    check_pkt("s2", 3, 16'h0100);
    check("s2_count", 64'(burst_count), 64'd2);
    check_quiet("s2");

    // S3: 40 words -> 16 + 16 back to back, then an 8-beat flush
    load(40, 16'h0200);
    drive(90, 0, 1'b0, 1'b0);
    check_pkt("s3", 40, 16'h0200);
    check("s3_count", 64'(burst_count), 64'd5);
    check_quiet("s3");

    // S4: random downstream backpressure
    load(16, 16'h0300);
    drive(150, 0, 1'b0, 1'b1);
    M_AXIS_TREADY = 1'b1;
    drive(6, 0, 1'b0, 1'b0);
    check_pkt("s4", 16, 16'h0300);
    check("s4_count", 64'(burst_count), 64'd6);
    check_quiet("s4");

    // S5: reset lands after 7 beats of a burst
    load(16, 16'h0400);
    drive(40, 7, 1'b0, 1'b0);
    check("s5_fires", 64'(fires), 64'd7);
    aresetn = 1'b0;
    #1;
    check("s5_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    check("s5_mlast", 64'(M_AXIS_TLAST), 64'd0);
    check("s5_mdata", 64'(M_AXIS_TDATA), 64'd0);
    check("s5_sready", 64'(S_AXIS_TREADY), 64'd0);
    check("s5_busy", 64'(busy), 64'd0);
    check("s5_count", 64'(burst_count), 64'd0);
    load(0, 0);
    #13;
    aresetn = 1'b1;
    drive(12, 0, 1'b0, 1'b0);
    check("s5_no_partial", 64'(got.size()), 64'd0);
    load(16, 16'h0500);
    drive(40, 0, 1'b0, 1'b0);
    check_pkt("s5", 16, 16'h0500);
    check("s5_count_after", 64'(burst_count), 64'd1);

    // S6: upstream valid toggles every cycle
    load(16, 16'h0600);
    busy_drops = 0;
    watch_busy = 1'b1;
    drive(80, 0, 1'b1, 1'b0);
    watch_busy = 1'b0;
    check_pkt("s6", 16, 16'h0600);
    check("s6_busy_drops", 64'(busy_drops), 64'd0);
    check("s6_count", 64'(burst_count), 64'd2);
    check_quiet("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
